calc_display_ctrl: RTL and testbench

- Sequencing controller for the 3-bit add/multiply calculator chip.
- Debounces the "go" button, latches operands, computes the sum or product, and converts it to tens/ones by iterative subtract-10.
- Time-multiplexes one active-low 7-segment bus across two digits, replacing the two static digit drivers.
- Sits between the raw Wokwi pins and the display.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/seg_decoder.sv | 27 ++
 rtl/calc_display_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_calc_display_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display controller.
// Pure declarations: no logic, no latency, no flow control.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CALC    = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } calc_state_t;

   // Active-low {a,b,c,d,e,f,g} patterns
   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h60;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h0C;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] DIGIT_OFF  = 2'b00;
   localparam logic [1:0] DIGIT_TENS = 2'b10;
   localparam logic [1:0] DIGIT_ONES = 2'b01;

   localparam logic SLOT_TENS = 1'b0;
   localparam logic SLOT_ONES = 1'b1;

   localparam logic [3:0] DIGIT_VAL_BLANK = 4'hF;

   // Sum or product of two 3-bit operands, zero-extended; max 49 fits in 6 bits.
   function automatic logic [5:0] calc_result(input logic [2:0] x,
                                              input logic [2:0] y,
                                              input logic       mul);
      return mul ? ({3'b000, x} * {3'b000, y}) : ({3'b000, x} + {3'b000, y});
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// 4-bit digit value to active-low 7-segment pattern; values above 9 blank.
// Purely combinational, zero latency, no flow control.
module seg_decoder
   import calc_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (value)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/calc_display_ctrl.sv
// Debounced go -> latch operands -> add/multiply -> tens/ones by subtract-10; two-digit muxed display.
// busy for 3+floor(R/10) cycles after start; seg registered (1 cycle); starts while busy are dropped.
module calc_display_ctrl
   import calc_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CYCLES = 16
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] a,
   input  logic [2:0] b,
   input  logic       op,
   input  logic       go,
   input  logic       show,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] dig_en,
   output logic       busy,
   output logic       valid
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

   // ---------------- go debouncer ----------------
   logic             go_s1;
   logic             go_s2;
   logic             go_stable;
   logic             go_stable_d;
   logic             start;
   logic [DEB_W-1:0] deb_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go_s1       <= 1'b0;
         go_s2       <= 1'b0;
         go_stable   <= 1'b0;
         go_stable_d <= 1'b0;
         start       <= 1'b0;
         deb_cnt     <= '0;
      end else begin
         go_s1       <= go;
         go_s2       <= go_s1;
         go_stable_d <= go_stable;
         start       <= go_stable & ~go_stable_d;
         if (go_s2 == go_stable) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            go_stable <= go_s2;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // ---------------- sequencing FSM ----------------
   calc_state_t state_q;
   calc_state_t state_d;

   logic [2:0] lat_a;
   logic [2:0] lat_b;
   logic       lat_op;
   logic [5:0] rem_q;
   logic [2:0] tacc_q;
   logic [3:0] tens_q;
   logic [3:0] ones_q;
   logic       busy_q;
   logic       valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_CALC;
         ST_CALC:    state_d = ST_CONVERT;
         ST_CONVERT: if (rem_q < 6'd10) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_a   <= '0;
         lat_b   <= '0;
         lat_op  <= 1'b0;
         rem_q   <= '0;
         tacc_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  lat_a   <= a;
                  lat_b   <= b;
                  lat_op  <= op;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_CALC: begin
               rem_q  <= calc_result(lat_a, lat_b, lat_op);
               tacc_q <= '0;
            end
            ST_CONVERT: begin
               // One decade per cycle; the quotient never exceeds 4.
               if (rem_q >= 6'd10) begin
                  rem_q  <= rem_q - 6'd10;
                  tacc_q <= tacc_q + 3'd1;
               end else begin
                  tens_q <= {1'b0, tacc_q};
                  ones_q <= rem_q[3:0];
               end
            end
            ST_DONE: begin
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ---------------- display scan ----------------
   logic [SCAN_W-1:0] scan_cnt;
   logic [SCAN_W-1:0] scan_cnt_d;
   logic              slot_q;
   logic              slot_d;
   logic [1:0]        dig_en_d;
   logic [1:0]        dig_en_q;

   always_comb begin
      scan_cnt_d = scan_cnt + 1'b1;
      slot_d     = slot_q;
      if (scan_cnt == SCAN_LAST) begin
         scan_cnt_d = '0;
         slot_d     = ~slot_q;
      end
      // Blank the enables on the first cycle of each slot so the previous digit never ghosts.
      if (scan_cnt_d == '0) begin
         dig_en_d = DIGIT_OFF;
      end else if (slot_d == SLOT_TENS) begin
         dig_en_d = DIGIT_TENS;
      end else begin
         dig_en_d = DIGIT_ONES;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         slot_q   <= SLOT_TENS;
         dig_en_q <= DIGIT_OFF;
      end else begin
         scan_cnt <= scan_cnt_d;
         slot_q   <= slot_d;
         dig_en_q <= dig_en_d;
      end
   end

   // ---------------- digit select and segment register ----------------
   logic [3:0] digit_val;
   logic [6:0] seg_dec;
   logic [6:0] seg_q;

   always_comb begin
      digit_val = DIGIT_VAL_BLANK;
      if (!show) begin
         digit_val = (slot_q == SLOT_TENS) ? {1'b0, a} : {1'b0, b};
      end else if (valid_q) begin
         digit_val = (slot_q == SLOT_TENS) ? tens_q : ones_q;
      end
   end

   seg_decoder u_seg_decoder (
      .value (digit_val),
      .seg   (seg_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_BLANK;
      end else begin
         seg_q <= seg_dec;
      end
   end

   assign seg    = seg_q;
   assign dp     = 1'b1;
   assign dig_en = dig_en_q;
   assign busy   = busy_q;
   assign valid  = valid_q;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Scoreboard bench for calc_display_ctrl: reference results pushed at stimulus, popped by a monitor.
module tb_calc_display_ctrl;

   localparam int SCAN_DIV = 8;
   localparam int DEB      = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] a = '0;
   logic [2:0] b = '0;
   logic       op = 1'b0;
   logic       go = 1'b0;
   logic       show = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] dig_en;
   logic       busy;
   logic       valid;

   calc_display_ctrl #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .op     (op),
      .go     (go),
      .show   (show),
      .seg    (seg),
      .dp     (dp),
      .dig_en (dig_en),
      .busy   (busy),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference segment table (digit -> active-low pattern)
   logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                7'h24, 7'h60, 7'h0F, 7'h00, 7'h0C};

   function automatic logic [6:0] enc(input int v);
      if (v >= 0 && v <= 9) return seg_tab[v];
      return 7'h7F;
   endfunction

   typedef struct {
      int         dur;
      logic [6:0] t_seg;
      logic [6:0] o_seg;
      string      name;
   } sb_item_t;

   sb_item_t sb[$];
   int push_cnt = 0;
   int done_cnt = 0;
   int drop_cnt = 0;
   int busy_rises = 0;

   task automatic push_exp(input int av, input int bv, input int opv, input string name);
      sb_item_t e;
      int r;
      r = (opv != 0) ? av * bv : av + bv;
      e.dur   = 3 + r / 10;
      e.t_seg = enc(r / 10);
      e.o_seg = enc(r % 10);
      e.name  = name;
      sb.push_back(e);
      push_cnt++;
   endtask

   // ---------------- monitor: result timing and result display ----------------
   bit       in_busy = 0;
   bit       bogus = 0;
   int       dur = 0;
   bit       disp_pend = 0;
   int       disp_cyc = 0;
   bit       m_seen_t = 0;
   bit       m_seen_o = 0;
   sb_item_t cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         if (in_busy && !bogus) drop_cnt++;
         in_busy   = 0;
         bogus     = 0;
         disp_pend = 0;
      end else if (busy && !in_busy) begin
         busy_rises++;
         in_busy   = 1;
         dur       = 1;
         disp_pend = 0;
         if (sb.size() == 0) begin
            bogus = 1;
            chk("unexpected_start", 1, 0);
         end else begin
            bogus = 0;
            cur   = sb.pop_front();
         end
      end else if (busy && in_busy) begin
         dur++;
      end else if (!busy && in_busy) begin
         in_busy = 0;
         if (!bogus) begin
            chk({cur.name, "_busy_cycles"}, dur, cur.dur);
            chk({cur.name, "_valid_after"}, valid, 1);
            disp_pend = 1;
            disp_cyc  = 0;
            m_seen_t  = 0;
            m_seen_o  = 0;
         end
         bogus = 0;
      end else if (disp_pend) begin
         disp_cyc++;
         if (dig_en == 2'b10) begin
            chk({cur.name, "_tens_seg"}, seg, cur.t_seg);
            m_seen_t = 1;
         end else if (dig_en == 2'b01) begin
            chk({cur.name, "_ones_seg"}, seg, cur.o_seg);
            m_seen_o = 1;
         end
         if (disp_cyc >= 2 * SCAN_DIV + 2) begin
            chk({cur.name, "_both_slots_seen"}, m_seen_t && m_seen_o, 1);
            disp_pend = 0;
            done_cnt++;
         end
      end
   end

   // ---------------- scan model: dig_en every cycle ----------------
   int cyc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc = 0;
      else        cyc++;
   end

   always @(negedge clk) begin
      logic [1:0] exp_en;
      if (rst_n) begin
         if (cyc % SCAN_DIV == 0)              exp_en = 2'b00;
         else if ((cyc / SCAN_DIV) % 2 == 0)   exp_en = 2'b10;
         else                                  exp_en = 2'b01;
         chk("dig_en_scan", dig_en, exp_en);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_sb(input string name);
      int t;
      t = 0;
      while ((done_cnt + drop_cnt != push_cnt) && t < 300) begin
         tick(1);
         t++;
      end
      chk({name, "_sb_drained"}, (done_cnt + drop_cnt == push_cnt), 1);
   endtask

   task automatic press(input int av, input int bv, input int opv, input string name);
      int k;
      a = 3'(av);
      b = 3'(bv);
      op = opv[0];
      show = 1'b1;
      push_exp(av, bv, opv, name);
      go = 1'b1;
      k = 0;
      do begin
         tick(1);
         k++;
      end while (!busy && k < 60);
      chk({name, "_start_latency"}, k, DEB + 4);
      wait_sb(name);
      go = 1'b0;
      tick(DEB + 4);
   endtask

   task automatic check_disp(input logic [6:0] et, input logic [6:0] eo, input string name);
      bit st;
      bit so;
      st = 0;
      so = 0;
      tick(2);
      for (int i = 0; i < 2 * SCAN_DIV + 2; i++) begin
         tick(1);
         if (dig_en == 2'b10) begin
            chk({name, "_tens"}, seg, et);
            st = 1;
         end else if (dig_en == 2'b01) begin
            chk({name, "_ones"}, seg, eo);
            so = 1;
         end
      end
      chk({name, "_slots_seen"}, st && so, 1);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_seg"}, seg, 7'h7F);
      chk({name, "_dig_en"}, dig_en, 2'b00);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_valid"}, valid, 0);
      chk({name, "_dp"}, dp, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int r0;
      int k;
      bit busy_seen;
      int av;
      int bv;

      rst_n = 1'b0;
      tick(3);
      chk_reset_vals("reset");
      #2 rst_n = 1'b1;
      show = 1'b1;
      check_disp(7'h7F, 7'h7F, "idle_blank");

      tick(5);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midscan_reset");
      tick(1);
      #2 rst_n = 1'b1;
      tick(DEB + 4);

      press(7, 7, 1, "mul77");
      press(5, 6, 0, "add56");

      // Bounce rejection: pulses one cycle too short, then one steady press
      r0 = busy_rises;
      busy_seen = 0;
      repeat (6) begin
         go = 1'b1;
         for (int i = 0; i < DEB - 1; i++) begin tick(1); busy_seen |= busy; end
         go = 1'b0;
         for (int i = 0; i < 3; i++) begin tick(1); busy_seen |= busy; end
      end
      for (int i = 0; i < DEB + 4; i++) begin tick(1); busy_seen |= busy; end
      chk("bounce_no_busy", busy_seen, 0);
      press(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), "steady");
      chk("bounce_one_start", busy_rises - r0, 1);

      // Busy interlock: second debounced press lands mid-CONVERT, operands zeroed after latch
      r0 = busy_rises;
      a = 3'd7; b = 3'd7; op = 1'b1; show = 1'b1;
      push_exp(7, 7, 1, "interlock");
      go = 1'b1;
      tick(DEB);
      go = 1'b0;
      tick(DEB);
      go = 1'b1;
      k = 0;
      while (!busy && k < 40) begin tick(1); k++; end
      chk("interlock_busy_seen", busy, 1);
      a = 3'd0; b = 3'd0;
      wait_sb("interlock");
      tick(12);
      chk("interlock_one_start", busy_rises - r0, 1);
      go = 1'b0;
      tick(DEB + 4);

      // Randomized operations against the reference model
      for (int n = 0; n < 10; n++) begin
         press(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), "rand");
      end

      // Randomized live operand display
      show = 1'b0;
      for (int n = 0; n < 4; n++) begin
         av = int'($urandom_range(0, 7));
         bv = int'($urandom_range(0, 7));
         a = 3'(av);
         b = 3'(bv);
         check_disp(enc(av), enc(bv), "live_rand");
      end

      // Abort during CONVERT
      r0 = drop_cnt;
      a = 3'd7; b = 3'd7; op = 1'b1; show = 1'b1;
      push_exp(7, 7, 1, "abort");
      go = 1'b1;
      k = 0;
      while (!busy && k < 40) begin tick(1); k++; end
      chk("abort_busy_seen", busy, 1);
      tick(3);
      go = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("abort_reset");
      tick(2);
      chk("abort_dropped", drop_cnt - r0, 1);
      #2 rst_n = 1'b1;
      check_disp(7'h7F, 7'h7F, "abort_blank");
      chk("abort_valid", valid, 0);
      show = 1'b0;
      a = 3'd3;
      b = 3'd2;
      check_disp(7'h06, 7'h12, "live_32");

      chk("final_queue_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

endmodule
